// File: rtl/uart_rx_core.sv
// UART receive engine: start-edge detect, mid-bit sampling, LSB-first assembly,
// stop-bit check, and a held output word with ready/framing/overrun flags.
module uart_rx_core #(
    parameter int CLKS_PER_BIT = 10,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serial_in,
    input  logic                 data_read,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 data_ready,
    output logic                 framing_error,
    output logic                 overrun_error,
    output logic                 rx_busy
);
    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        LOAD  = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic                   prev_q;
    logic [TW-1:0]          timer_q, timer_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   stop_q, stop_d;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   ready_q, ready_d;
    logic                   ferr_q, ferr_d;
    logic                   over_q, over_d;
    logic                   fall;

    assign fall = prev_q & ~serial_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            prev_q    <= 1'b1;
            timer_q   <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            stop_q    <= 1'b1;
            rx_data_q <= '0;
            ready_q   <= 1'b0;
            ferr_q    <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= serial_in;
            timer_q   <= timer_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            stop_q    <= stop_d;
            rx_data_q <= rx_data_d;
            ready_q   <= ready_d;
            ferr_q    <= ferr_d;
            over_q    <= over_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        stop_d    = stop_q;
        rx_data_d = rx_data_q;
        ready_d   = ready_q;
        ferr_d    = ferr_q;
        over_d    = over_q;

        // Consumer acknowledge; a LOAD in the same cycle overrides below.
        if (ready_q && data_read) begin
            ready_d = 1'b0;
            over_d  = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d = START;
                    timer_d = '0;
                end
            end
            START: begin
                if (timer_q == T_HALF) begin
                    timer_d = '0;
                    if (!serial_in) begin
                        state_d = DATA;
                        bit_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            DATA: begin
                if (timer_q == T_LAST) begin
                    timer_d = '0;
                    shift_d = {serial_in, shift_q[DATA_BITS-1:1]};
                    if (bit_q == B_LAST) state_d = STOP;
                    else                 bit_d   = bit_q + BW'(1);
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            STOP: begin
                if (timer_q == T_LAST) begin
                    timer_d = '0;
                    stop_d  = serial_in;
                    state_d = LOAD;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            LOAD: begin
                rx_data_d = shift_q;
                ready_d   = 1'b1;
                ferr_d    = ~stop_q;
                over_d    = ready_q & ~data_read;
                timer_d   = '0;
                state_d   = fall ? START : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx_data       = rx_data_q;
    assign data_ready    = ready_q;
    assign framing_error = ferr_q;
    assign overrun_error = over_q;
    assign rx_busy       = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: frames are driven bit-period by bit-period and the
// outputs compared against a frame-level model of the receiver's visible state.
module tb_uart_rx_core;
    localparam int C      = 10;
    localparam int N      = 8;
    localparam int H      = C / 2;
    localparam int LOAD_K = H + (N + 1) * C + 1;  // cycle offset of the LOAD state

    logic         clk = 1'b0;
    logic         rst;
    logic         serial_in;
    logic         data_read;
    logic [N-1:0] rx_data;
    logic         data_ready;
    logic         framing_error;
    logic         overrun_error;
    logic         rx_busy;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [N-1:0] exp_data;
    logic         exp_ready;
    logic         exp_ferr;
    logic         exp_over;

    uart_rx_core #(.CLKS_PER_BIT(C), .DATA_BITS(N)) dut (
        .clk           (clk),
        .rst           (rst),
        .serial_in     (serial_in),
        .data_read     (data_read),
        .rx_data       (rx_data),
        .data_ready    (data_ready),
        .framing_error (framing_error),
        .overrun_error (overrun_error),
        .rx_busy       (rx_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        exp_data  = '0;
        exp_ready = 1'b0;
        exp_ferr  = 1'b0;
        exp_over  = 1'b0;
    endtask

    task automatic read_pulse();
        data_read = 1'b1;
        tick();
        data_read = 1'b0;
        if (exp_ready) begin
            exp_ready = 1'b0;
            exp_over  = 1'b0;
        end
    endtask

    // Idle-high gap, then a full frame; checks busy window and the load result.
    task automatic send_frame(input logic [N-1:0] d, input logic stop,
                              input int gap, input logic read_at_load, input string tag);
        logic b;
        int   idx;
        serial_in = 1'b1;
        repeat (gap) tick();
        for (int k = 0; k < (N + 2) * C; k++) begin
            idx = k / C;
            if (idx == 0)      b = 1'b0;
            else if (idx <= N) b = d[idx-1];
            else               b = stop;
            serial_in = b;
            tick();
            if (k + 1 == 1) begin
                n_cmp++;
                if (rx_busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s busy_after_edge: got %b expected 1", tag, rx_busy);
                end
            end
            if (k + 1 == LOAD_K) begin
                n_cmp++;
                if (rx_busy !== 1'b1 || data_ready !== exp_ready) begin
                    n_fail++;
                    $display("FAIL %s pre_load: busy=%b ready=%b expected busy=1 ready=%b",
                             tag, rx_busy, data_ready, exp_ready);
                end
                if (read_at_load) data_read = 1'b1;
            end
            if (k + 1 == LOAD_K + 1) begin
                data_read = 1'b0;
                exp_over  = exp_ready & ~read_at_load;
                exp_ready = 1'b1;
                exp_data  = d;
                exp_ferr  = ~stop;
                n_cmp++;
                if (rx_busy !== 1'b0 || rx_data !== exp_data || data_ready !== exp_ready ||
                    framing_error !== exp_ferr || overrun_error !== exp_over) begin
                    n_fail++;
                    $display("FAIL %s load: got busy=%b data=%h rdy=%b ferr=%b ovr=%b expected busy=0 data=%h rdy=%b ferr=%b ovr=%b",
                             tag, rx_busy, rx_data, data_ready, framing_error, overrun_error,
                             exp_data, exp_ready, exp_ferr, exp_over);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; serial_in = 1'b1; data_read = 1'b0;
        model_clear();
        tick(); tick();
        n_cmp++;
        if ({rx_data, data_ready, framing_error, overrun_error, rx_busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: got data=%h rdy=%b ferr=%b ovr=%b busy=%b expected all 0",
                     rx_data, data_ready, framing_error, overrun_error, rx_busy);
        end
        rst = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if ({rx_data, data_ready, framing_error, overrun_error, rx_busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_release: got data=%h rdy=%b ferr=%b ovr=%b busy=%b expected all 0",
                     rx_data, data_ready, framing_error, overrun_error, rx_busy);
        end
    endtask

    task automatic test_basic();
        send_frame(8'hA5, 1'b1, 3, 1'b0, "basic_a5");
    endtask

    task automatic test_false_start();
        serial_in = 1'b1;
        repeat (4) tick();
        for (int k = 0; k < 12; k++) begin
            serial_in = (k < 3) ? 1'b0 : 1'b1;
            tick();
            if (k + 1 == 1 || k + 1 == H) begin
                n_cmp++;
                if (rx_busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL glitch_busy_at_%0d: got %b expected 1", k + 1, rx_busy);
                end
            end
            if (k + 1 == H + 1) begin
                n_cmp++;
                if (rx_busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL glitch_idle_at_%0d: got %b expected 0", k + 1, rx_busy);
                end
            end
        end
        n_cmp++;
        if (rx_data !== exp_data || data_ready !== exp_ready ||
            framing_error !== exp_ferr || overrun_error !== exp_over) begin
            n_fail++;
            $display("FAIL glitch_outputs: got data=%h rdy=%b ferr=%b ovr=%b expected data=%h rdy=%b ferr=%b ovr=%b",
                     rx_data, data_ready, framing_error, overrun_error,
                     exp_data, exp_ready, exp_ferr, exp_over);
        end
    endtask

    task automatic test_framing();
        read_pulse();
        send_frame(8'h3C, 1'b0, 2, 1'b0, "framing_3c");
        read_pulse();
        send_frame(8'h01, 1'b1, 2, 1'b0, "framing_recover_01");
    endtask

    task automatic test_back_to_back();
        read_pulse();
        send_frame(8'h11, 1'b1, 2, 1'b0, "b2b_11");
        send_frame(8'h22, 1'b1, 0, 1'b0, "b2b_22");
        read_pulse();
        n_cmp++;
        if (data_ready !== 1'b0 || overrun_error !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_read_clear: got rdy=%b ovr=%b expected 0 0", data_ready, overrun_error);
        end
    endtask

    task automatic test_read_at_load();
        send_frame(8'h11, 1'b1, 2, 1'b0, "ral_11");
        send_frame(8'h22, 1'b1, 0, 1'b1, "ral_22");
    endtask

    task automatic test_reset_mid_frame();
        logic [N-1:0] d;
        d = 8'hFF;
        read_pulse();
        serial_in = 1'b1;
        repeat (2) tick();
        for (int k = 0; k < 5 * C + H; k++) begin
            serial_in = (k < C) ? 1'b0 : d[k / C - 1];
            tick();
        end
        rst = 1'b1;
        serial_in = 1'b1;
        #1;
        model_clear();
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if ({rx_data, data_ready, framing_error, overrun_error, rx_busy} !== '0) begin
                n_fail++;
                $display("FAIL midframe_reset_%0d: got data=%h rdy=%b ferr=%b ovr=%b busy=%b expected all 0",
                         i, rx_data, data_ready, framing_error, overrun_error, rx_busy);
            end
            tick();
        end
        rst = 1'b0;
        tick();
        send_frame(8'h5A, 1'b1, 2, 1'b0, "after_reset_5a");
    endtask

    task automatic test_random();
        logic [N-1:0] d;
        logic         stop, prev_stop;
        int           gap;
        prev_stop = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(0, 1) == 1) read_pulse();
            d    = N'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            gap  = prev_stop ? $urandom_range(0, 3) : $urandom_range(1, 3);
            send_frame(d, stop, gap, ($urandom_range(0, 3) == 0), $sformatf("rand_%0d", i));
            prev_stop = stop;
        end
    endtask

    task automatic test_break();
        read_pulse();
        serial_in = 1'b1;
        repeat (2) tick();
        serial_in = 1'b0;
        for (int k = 0; k < 3 * (N + 2) * C; k++) begin
            tick();
            if (k + 1 == LOAD_K + 1) begin
                exp_over = 1'b0; exp_ready = 1'b1; exp_data = '0; exp_ferr = 1'b1;
                n_cmp++;
                if (rx_data !== exp_data || data_ready !== 1'b1 || framing_error !== 1'b1) begin
                    n_fail++;
                    $display("FAIL break_load: got data=%h rdy=%b ferr=%b expected 00 1 1",
                             rx_data, data_ready, framing_error);
                end
            end
        end
        n_cmp++;
        if (rx_busy !== 1'b0 || data_ready !== 1'b1 || overrun_error !== 1'b0) begin
            n_fail++;
            $display("FAIL break_no_restart: got busy=%b rdy=%b ovr=%b expected 0 1 0",
                     rx_busy, data_ready, overrun_error);
        end
        serial_in = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_false_start();
        test_framing();
        test_back_to_back();
        test_read_at_load();
        test_reset_mid_frame();
        test_random();
        test_break();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
